traffic_light_conflict_monitor: RTL
===================================

// Module: traffic_light_conflict_monitor
// PURPOSE
//  Independent watchdog on the six lamp outputs of the traffic light controller.
//  Reads both roads' R/Y/G lamps each cycle, checks safety and sequence rules,
//  latches the first fault with a code, and drives a flash-mode request to the lamp drivers.
//  Sits beside the controller at top level. It observes only and never drives the controller.
// PARAMETERS
//  MIN_YELLOW_CYCLES  3  minimum consecutive yellow cycles before red is legal
//  GLITCH_CYCLES      2  consecutive dark/multi-lamp cycles tolerated; fault on the last one
//  FLASH_HALF_CYCLES  5  o_flash half-period while faulted
// PORTS
//  i_clk          in   1  clock, rising edge
//  i_reset        in   1  synchronous, active-high reset
//  i_Main_red     in   1  main road red lamp
//  i_Main_yellow  in   1  main road yellow lamp
//  i_Main_green   in   1  main road green lamp
//  i_Side_red     in   1  side road red lamp
//  i_Side_yellow  in   1  side road yellow lamp
//  i_Side_green   in   1  side road green lamp
//  i_fault_clear  in   1  operator clear; acted on only in S_FAULT
//  o_armed        out  1  1 in S_RUN (sequence checks active)
//  o_fault        out  1  latched fault flag
//  o_fault_code   out  3  0 none, 1 CONFLICT, 2 MULTI, 3 DARK, 4 SEQ, 5 SHORT_YEL
//  o_fault_road   out  1  0 main, 1 side; 0 for CONFLICT
//  o_flash        out  1  flash request, toggling in S_FAULT
// BEHAVIOUR
//  - Reset: all outputs 0. State S_INIT. Counters 0. Held phases = RED. Reset mid-fault also clears the fault.
//  - Per road decode: exactly one lamp lit gives phase R/Y/G (valid). 000 is dark. Two or more lamps is multi.
//  - Held phase: updates only on valid samples. Dark/multi samples keep the last valid phase.
//  - CONFLICT: both roads valid and both non-red in the same sample.
//    Checked in S_INIT and S_RUN, with no filter.
//  - MULTI/DARK: per-road counter of consecutive bad samples, saturating, cleared by a valid sample.
//    Fault when the counter reaches GLITCH_CYCLES. Checked in S_INIT and S_RUN.
//  - SEQ (S_RUN only): legal held-phase changes are G->Y, Y->R and R->G.
//    G->R, R->Y and Y->G are faults, compared against the held phase across dark/multi gaps.
//  - SHORT_YEL (S_RUN only): per-road yellow counter counts consecutive yellow samples, saturating at MIN_YELLOW_CYCLES.
//    Y->R with count < MIN_YELLOW_CYCLES is a fault. The counter clears on leaving yellow.
//  - Simultaneous faults: the lowest code wins. If both roads fault on the same code, the main road wins.
//  - Latency: violations are detected combinationally on the current sample.
//    o_fault, o_fault_code and o_fault_road register at that edge and are visible the next cycle.
//  - FSM:
//    - S_INIT -> S_RUN when both roads are valid and at least one is red in the same sample (o_armed=1 next cycle).
//    - S_INIT/S_RUN -> S_FAULT on any fault.
//    - S_FAULT: code and road frozen; later violations are ignored.
//    - S_FAULT -> S_INIT when i_fault_clear=1. Outputs return to 0 next cycle; counters clear.
//  - Flash: on entering S_FAULT, o_flash=1. It toggles every FLASH_HALF_CYCLES cycles while in S_FAULT, otherwise 0.
//  - Widths: counters are $clog2(max param + 1) bits and never wrap (saturating).
// STRUCTURE
//  - traffic_pkg: phase encoding (R/Y/G), FSM state encoding, fault code localparams (3-bit).
//  - Sub-module tlm_road_checker, instanced twice (main, side).
//    Contains: one-hot decode, held phase, glitch counter, yellow counter, per-road SEQ/SHORT_YEL/MULTI/DARK flags.
//  - Top holds the CONFLICT check, priority encode, FSM and flash counter.
// TESTING (CLK_PERIOD 10, defaults)
//  1. Reset 2 cycles, then main G / side R for 50 cycles
//     -> o_armed=1 one cycle after the first valid sample, o_fault=0 throughout.
//  2. Legal cycle main G->Y(3 cycles)->R, side R->G->Y(3 cycles)->R, repeated 3 times -> o_fault stays 0.
//  3. Main Y for 2 cycles then R -> o_fault=1, code 5, road 0.
//     o_flash=1, toggles every 5 cycles.
//  4. Main G and side G in the same sample -> code 1 next cycle.
//     A following side dark sample leaves the code at 1.
//  5. Side all-off for 1 cycle then R -> no fault.
//     Side all-off for 2 cycles -> code 3, road 1.
//     Main R+G for 2 cycles in the same sample as the side fault -> code 2, road 0.
//  6. In S_FAULT assert i_fault_clear -> o_fault=0, o_flash=0, o_armed=0.
//     Re-arms on the next valid pair.
//     Reset during S_RUN -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light conflict monitor: lamp phases,
// monitor FSM states, fault codes and the per-road fault flag bundle.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_RED = 2'd0,
    PH_YEL = 2'd1,
    PH_GRN = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_CONFLICT  = 3'd1;
  localparam logic [2:0] FC_MULTI     = 3'd2;
  localparam logic [2:0] FC_DARK      = 3'd3;
  localparam logic [2:0] FC_SEQ       = 3'd4;
  localparam logic [2:0] FC_SHORT_YEL = 3'd5;

  typedef struct packed {
    logic multi;
    logic dark;
    logic seq;
    logic short_yel;
  } road_flags_t;

  // Staying in the same phase is always fine; only G->Y, Y->R, R->G move forward.
  function automatic logic legal_step(input phase_t held, input phase_t cur);
    legal_step = (held == cur)
              || (held == PH_GRN && cur == PH_YEL)
              || (held == PH_YEL && cur == PH_RED)
              || (held == PH_RED && cur == PH_GRN);
  endfunction

endpackage

// File: rtl/tlm_road_checker.sv
// Per-road lamp checker: decodes the R/Y/G lamps, tracks the last valid phase,
// and raises MULTI/DARK/SEQ/SHORT_YEL flags for the current sample.
module tlm_road_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW_CYCLES = 3,
  parameter int GLITCH_CYCLES     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_red,
  input  logic        i_yellow,
  input  logic        i_green,
  input  logic        i_clear,
  input  logic        i_run,
  output logic        o_valid,
  output phase_t      o_phase,
  output road_flags_t o_flags
);

  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam int YW = $clog2(MIN_YELLOW_CYCLES + 1);
  localparam logic [GW-1:0] GLITCH_MAX  = GW'(GLITCH_CYCLES);
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
  localparam logic [YW-1:0] YEL_MAX     = YW'(MIN_YELLOW_CYCLES);

  logic [2:0]    w_lamps;
  logic          w_valid;
  logic          w_dark;
  logic          w_multi;
  phase_t        w_phase;
  logic          w_glitch_hit;

  phase_t        r_held;
  logic [GW-1:0] r_glitch_cnt;
  logic [YW-1:0] r_yel_cnt;

  assign w_lamps = {i_red, i_yellow, i_green};

  always_comb begin
    w_valid = 1'b0;
    w_dark  = 1'b0;
    w_multi = 1'b0;
    w_phase = PH_RED;
    case (w_lamps)
      3'b100:  begin w_valid = 1'b1; w_phase = PH_RED; end
      3'b010:  begin w_valid = 1'b1; w_phase = PH_YEL; end
      3'b001:  begin w_valid = 1'b1; w_phase = PH_GRN; end
      3'b000:  w_dark  = 1'b1;
      default: w_multi = 1'b1;
    endcase
  end

  // The bad sample that brings the run length up to GLITCH_CYCLES is the faulting one.
  assign w_glitch_hit = (w_dark || w_multi) && (r_glitch_cnt >= GLITCH_LAST);

  always_comb begin
    o_flags.multi     = w_multi && w_glitch_hit;
    o_flags.dark      = w_dark && w_glitch_hit;
    o_flags.seq       = i_run && w_valid && !legal_step(r_held, w_phase);
    o_flags.short_yel = i_run && w_valid && (r_held == PH_YEL) && (w_phase == PH_RED)
                        && (r_yel_cnt < YEL_MAX);
  end

  assign o_valid = w_valid;
  assign o_phase = w_phase;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_held       <= PH_RED;
      r_glitch_cnt <= '0;
      r_yel_cnt    <= '0;
    end else begin
      if (w_valid) begin
        r_held <= w_phase;
      end

      if (i_clear || w_valid) begin
        r_glitch_cnt <= '0;
      end else if (r_glitch_cnt != GLITCH_MAX) begin
        r_glitch_cnt <= r_glitch_cnt + GW'(1);
      end

      // Dark/multi gaps inside a yellow stretch neither count nor reset the run.
      if (i_clear || (w_valid && w_phase != PH_YEL)) begin
        r_yel_cnt <= '0;
      end else if (w_valid && r_yel_cnt != YEL_MAX) begin
        r_yel_cnt <= r_yel_cnt + YW'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_light_conflict_monitor.sv
// Independent watchdog on the six lamp outputs: checks conflict and sequence rules,
// latches the first fault with its code and road, and requests lamp flashing.
module traffic_light_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW_CYCLES = 3,
  parameter int GLITCH_CYCLES     = 2,
  parameter int FLASH_HALF_CYCLES = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_Main_red,
  input  logic       i_Main_yellow,
  input  logic       i_Main_green,
  input  logic       i_Side_red,
  input  logic       i_Side_yellow,
  input  logic       i_Side_green,
  input  logic       i_fault_clear,
  output logic       o_armed,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic       o_fault_road,
  output logic       o_flash
);

  localparam int FW = $clog2(FLASH_HALF_CYCLES + 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF_CYCLES - 1);

  logic [2:0]    w_lamps [2];
  logic          w_valid [2];
  phase_t        w_phase [2];
  road_flags_t   w_flags [2];

  logic          w_checking;
  logic          w_run;
  logic          w_clear;
  logic          w_conflict;
  logic          w_arm;
  logic [2:0]    w_code;
  logic          w_road;
  logic          w_fault_hit;

  state_t        r_state;
  logic          r_armed;
  logic          r_fault;
  logic [2:0]    r_code;
  logic          r_road;
  logic          r_flash;
  logic [FW-1:0] r_flash_cnt;

  assign w_lamps[0] = {i_Main_red, i_Main_yellow, i_Main_green};
  assign w_lamps[1] = {i_Side_red, i_Side_yellow, i_Side_green};

  assign w_checking = (r_state != S_FAULT);
  assign w_run      = (r_state == S_RUN);
  assign w_clear    = (r_state == S_FAULT) && i_fault_clear;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_road
      tlm_road_checker #(
        .MIN_YELLOW_CYCLES (MIN_YELLOW_CYCLES),
        .GLITCH_CYCLES     (GLITCH_CYCLES)
      ) u_checker (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_red    (w_lamps[gi][2]),
        .i_yellow (w_lamps[gi][1]),
        .i_green  (w_lamps[gi][0]),
        .i_clear  (w_clear),
        .i_run    (w_run),
        .o_valid  (w_valid[gi]),
        .o_phase  (w_phase[gi]),
        .o_flags  (w_flags[gi])
      );
    end
  endgenerate

  assign w_conflict = w_valid[0] && w_valid[1]
                   && (w_phase[0] != PH_RED) && (w_phase[1] != PH_RED);
  assign w_arm      = w_valid[0] && w_valid[1]
                   && ((w_phase[0] == PH_RED) || (w_phase[1] == PH_RED));

  // Lowest code wins; within a code the main road (index 0) wins.
  always_comb begin
    w_code = FC_NONE;
    w_road = 1'b0;
    if (w_conflict) begin
      w_code = FC_CONFLICT;
    end else if (w_flags[0].multi || w_flags[1].multi) begin
      w_code = FC_MULTI;
      w_road = !w_flags[0].multi;
    end else if (w_flags[0].dark || w_flags[1].dark) begin
      w_code = FC_DARK;
      w_road = !w_flags[0].dark;
    end else if (w_flags[0].seq || w_flags[1].seq) begin
      w_code = FC_SEQ;
      w_road = !w_flags[0].seq;
    end else if (w_flags[0].short_yel || w_flags[1].short_yel) begin
      w_code = FC_SHORT_YEL;
      w_road = !w_flags[0].short_yel;
    end
  end

  assign w_fault_hit = w_checking && (w_code != FC_NONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_INIT;
      r_armed     <= 1'b0;
      r_fault     <= 1'b0;
      r_code      <= FC_NONE;
      r_road      <= 1'b0;
      r_flash     <= 1'b0;
      r_flash_cnt <= '0;
    end else begin
      case (r_state)
        S_INIT, S_RUN: begin
          if (w_fault_hit) begin
            r_state     <= S_FAULT;
            r_armed     <= 1'b0;
            r_fault     <= 1'b1;
            r_code      <= w_code;
            r_road      <= w_road;
            r_flash     <= 1'b1;
            r_flash_cnt <= '0;
          end else if (r_state == S_INIT && w_arm) begin
            r_state <= S_RUN;
            r_armed <= 1'b1;
          end
        end
        S_FAULT: begin
          if (i_fault_clear) begin
            r_state     <= S_INIT;
            r_armed     <= 1'b0;
            r_fault     <= 1'b0;
            r_code      <= FC_NONE;
            r_road      <= 1'b0;
            r_flash     <= 1'b0;
            r_flash_cnt <= '0;
          end else if (r_flash_cnt == FLASH_LAST) begin
            r_flash     <= !r_flash;
            r_flash_cnt <= '0;
          end else begin
            r_flash_cnt <= r_flash_cnt + FW'(1);
          end
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  assign o_armed      = r_armed;
  assign o_fault      = r_fault;
  assign o_fault_code = r_code;
  assign o_fault_road = r_road;
  assign o_flash      = r_flash;

endmodule
